// File: rtl/axis_adder.sv
// AXI4-Stream packet summer: accumulates the beats of each packet and pulses the total.
// Optional AXIS_ADDER_SATURATE_EN: additions clamp at all-ones instead of wrapping.
module axis_adder #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  axis_adder_tvalid,
    input  logic                  axis_adder_tlast,
    input  logic [DATA_WIDTH-1:0] axis_adder_tdata,
    output logic                  axis_adder_tready,
    output logic                  response_valid,
    output logic [DATA_WIDTH-1:0] response
);

    typedef enum logic {
        ACCUM = 1'b0,
        RESP  = 1'b1
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] sum_c;
    logic                  beat_c;

    assign beat_c = axis_adder_tvalid && axis_adder_tready;

`ifdef AXIS_ADDER_SATURATE_EN
    // Carry out of the widened sum means the true total no longer fits: clamp.
    logic [DATA_WIDTH:0] wide_sum_c;
    assign wide_sum_c = {1'b0, acc} + {1'b0, axis_adder_tdata};
    assign sum_c      = wide_sum_c[DATA_WIDTH] ? '1 : wide_sum_c[DATA_WIDTH-1:0];
`else
    assign sum_c = acc + axis_adder_tdata;
`endif

    // Accumulate in ACCUM; RESP is the single bubble cycle carrying the result pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= ACCUM;
            acc               <= '0;
            response          <= '0;
            response_valid    <= 1'b0;
            axis_adder_tready <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    axis_adder_tready <= 1'b1;
                    response_valid    <= 1'b0;
                    if (beat_c) begin
                        if (axis_adder_tlast) begin
                            response          <= sum_c;
                            acc               <= '0;
                            response_valid    <= 1'b1;
                            axis_adder_tready <= 1'b0;
                            state             <= RESP;
                        end else begin
                            acc <= sum_c;
                        end
                    end
                end
                RESP: begin
                    response_valid    <= 1'b0;
                    axis_adder_tready <= 1'b1;
                    state             <= ACCUM;
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_adder.sv
// Directed testbench for axis_adder: hand-computed packet sums, bubbles, gaps and reset.
module tb_axis_adder;

    localparam int unsigned DATA_WIDTH = 64;

    logic                  clk;
    logic                  rst_n;
    logic                  tvalid;
    logic                  tlast;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tready;
    logic                  response_valid;
    logic [DATA_WIDTH-1:0] response;

    int vectors;
    int errors;
    int pulses;
    int stalls;
    int base;

    axis_adder #(.DATA_WIDTH(DATA_WIDTH)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .axis_adder_tvalid (tvalid),
        .axis_adder_tlast  (tlast),
        .axis_adder_tdata  (tdata),
        .axis_adder_tready (tready),
        .response_valid    (response_valid),
        .response          (response)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (response_valid) pulses++;
    end

    task automatic check(input string tag, input logic [DATA_WIDTH-1:0] obs,
                         input logic [DATA_WIDTH-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold no valid beat; tdata/tlast carry junk that must be ignored.
    task automatic idle();
        tvalid = 1'b0;
        tlast  = 1'b1;
        tdata  = 64'hDEAD_BEEF_0BAD_F00D;
    endtask

    // Present one beat and wait until an edge accepts it; returns cycles spent with tready low.
    task automatic send_beat(input logic [DATA_WIDTH-1:0] d, input logic l, output int n_stall);
        logic rdy;
        n_stall = 0;
        tvalid  = 1'b1;
        tdata   = d;
        tlast   = l;
        for (int k = 0; k < 50; k++) begin
            rdy = tready;
            tick();
            if (rdy) return;
            n_stall++;
        end
        errors++;
        $error("FAIL timeout waiting for tready observed=0 expected=1");
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        pulses  = 0;
        rst_n   = 1'b0;
        idle();

        // Reset state
        tick();
        tick();
        check("reset_tready", 64'(tready), 64'd0);
        check("reset_valid", 64'(response_valid), 64'd0);
        check("reset_response", response, 64'd0);
        rst_n = 1'b1;
        tick();
        check("post_reset_tready", 64'(tready), 64'd1);

        // Packet 1..20, tvalid held high
        base = pulses;
        for (int i = 1; i <= 20; i++) send_beat(64'(i), i == 20, stalls);
        idle();
        check("seq20_valid", 64'(response_valid), 64'd1);
        check("seq20_response", response, 64'd210);
        check("seq20_bubble", 64'(tready), 64'd0);
        tick();
        check("seq20_valid_drop", 64'(response_valid), 64'd0);
        check("seq20_tready_back", 64'(tready), 64'd1);
        tick();
        check("seq20_pulses", 64'(pulses - base), 64'd1);

        // Single-beat packet, then a packet proving acc was cleared
        send_beat(64'd5, 1'b1, stalls);
        idle();
        check("single_response", response, 64'd5);
        check("single_valid", 64'(response_valid), 64'd1);
        send_beat(64'd7, 1'b0, stalls);
        send_beat(64'd8, 1'b1, stalls);
        idle();
        check("clear_response", response, 64'd15);

        // Packet 1..20 with 3-cycle tvalid gaps after every 4th beat
        tick();
        base = pulses;
        for (int i = 1; i <= 20; i++) begin
            send_beat(64'(i), i == 20, stalls);
            if (i % 4 == 0 && i != 20) begin
                idle();
                tick();
                tick();
                tick();
                check("gap_no_pulse", 64'(response_valid), 64'd0);
            end
        end
        idle();
        check("gap_response", response, 64'd210);
        tick();
        tick();
        check("gap_pulses", 64'(pulses - base), 64'd1);

        // Overflow: all-ones + 2
        send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, stalls);
        send_beat(64'd2, 1'b1, stalls);
        idle();
`ifdef AXIS_ADDER_SATURATE_EN
        check("overflow_response", response, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        check("overflow_response", response, 64'd1);
`endif

        // Reset mid-packet discards the partial sum
        tick();
        send_beat(64'd10, 1'b0, stalls);
        send_beat(64'd20, 1'b0, stalls);
        idle();
        base  = pulses;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midreset_tready", 64'(tready), 64'd0);
        check("midreset_response", response, 64'd0);
        check("midreset_valid", 64'(response_valid), 64'd0);
        send_beat(64'd3, 1'b1, stalls);
        idle();
        check("midreset_final", response, 64'd3);
        check("midreset_pulses", 64'(pulses - base), 64'd0);
        tick();

        // Back-to-back packets {1,2(last)} {4(last)}, tvalid held high
        send_beat(64'd1, 1'b0, stalls);
        send_beat(64'd2, 1'b1, stalls);
        check("b2b_first_response", response, 64'd3);
        check("b2b_bubble", 64'(tready), 64'd0);
        send_beat(64'd4, 1'b1, stalls);
        idle();
        check("b2b_stall_cycles", 64'(stalls), 64'd1);
        check("b2b_second_response", response, 64'd4);
        check("b2b_second_valid", 64'(response_valid), 64'd1);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
